// File: rtl/sprite_mem_writer_if.sv
// rtl/sprite_mem_writer_if.sv - command, pixel-stream, blanking and RAM-write bundle for sprite_mem_writer
//
// Ports (signals carried by the interface):
//   cmd_valid/cmd_ready, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colr  rectangle command handshake
//   pix_valid/pix_ready, pix_data                                      STREAM pixel handshake
//   blank                                                              safe-write window
//   wr_en, wr_addr, wr_data                                            sprite RAM write port
//   busy, done, err                                                    status
// Modports: slave = the writer block, master = the command/pixel source.
interface sprite_mem_writer_if #(
    parameter int COLR_BITS = 12,
    parameter int ADDRW     = 7,
    parameter int XW        = 4,
    parameter int YW        = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [XW-1:0]        cmd_x;
    logic [YW-1:0]        cmd_y;
    logic [XW-1:0]        cmd_w;
    logic [YW-1:0]        cmd_h;
    logic [COLR_BITS-1:0] cmd_colr;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [COLR_BITS-1:0] pix_data;
    logic                 blank;
    logic                 wr_en;
    logic [ADDRW-1:0]     wr_addr;
    logic [COLR_BITS-1:0] wr_data;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colr,
        input  pix_valid, pix_data, blank,
        output cmd_ready, pix_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colr,
        output pix_valid, pix_data, blank,
        input  cmd_ready, pix_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/sprite_mem_writer.sv
// rtl/sprite_mem_writer.sv - rectangle STREAM/FILL/CLEAR writer for a dual-port sprite RAM
//
// Ports:
//   clk_pix  in   pixel clock, single domain
//   rst_n    in   synchronous active-low reset
//   bus      slave modport of sprite_mem_writer_if (command, pixel stream, blank, RAM write, status)
module sprite_mem_writer #(
    parameter int                   WIDTH           = 10,
    parameter int                   HEIGHT          = 10,
    parameter int                   COLR_BITS       = 12,
    parameter logic [COLR_BITS-1:0] TRANSPARENT_VAL = 12'h888,
    parameter int                   ADDRW           = $clog2(WIDTH*HEIGHT),
    parameter int                   XW              = $clog2(WIDTH+1),
    parameter int                   YW              = $clog2(HEIGHT+1)
) (
    input  logic                 clk_pix,
    input  logic                 rst_n,
    sprite_mem_writer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_STREAM = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [XW-1:0]    X_ONE    = XW'(1);
    localparam logic [YW-1:0]    Y_ONE    = YW'(1);
    localparam logic [XW-1:0]    X_FULL   = XW'(WIDTH);
    localparam logic [YW-1:0]    Y_FULL   = YW'(HEIGHT);
    localparam logic [XW:0]      X_LIMIT  = (XW+1)'(WIDTH);
    localparam logic [YW:0]      Y_LIMIT  = (YW+1)'(HEIGHT);
    localparam logic [ADDRW-1:0] A_STRIDE = ADDRW'(WIDTH);

    state_t r_state;
    state_t w_next_state;

    logic [1:0]           r_op;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [XW-1:0]        r_w;
    logic [YW-1:0]        r_h;
    logic [COLR_BITS-1:0] r_colr;
    logic [ADDRW-1:0]     r_addr;
    logic [ADDRW-1:0]     r_row_base;
    logic [XW-1:0]        r_col;
    logic [YW-1:0]        r_row;
    logic                 r_wr_en;
    logic [ADDRW-1:0]     r_wr_addr;
    logic [COLR_BITS-1:0] r_wr_data;

    logic [XW-1:0]        w_eff_x;
    logic [YW-1:0]        w_eff_y;
    logic [XW-1:0]        w_eff_w;
    logic [YW-1:0]        w_eff_h;
    logic [XW:0]          w_x_end;
    logic [YW:0]          w_y_end;
    logic                 w_reject;
    logic [ADDRW-1:0]     w_start_addr;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_consume;
    logic [COLR_BITS-1:0] w_elem_data;
    logic [ADDRW-1:0]     w_next_row_base;

    // CLEAR ignores the latched rectangle and covers the whole sprite.
    assign w_eff_x = (r_op == OP_CLEAR) ? '0     : r_x;
    assign w_eff_y = (r_op == OP_CLEAR) ? '0     : r_y;
    assign w_eff_w = (r_op == OP_CLEAR) ? X_FULL : r_w;
    assign w_eff_h = (r_op == OP_CLEAR) ? Y_FULL : r_h;

    // One extra bit so x+w / y+h cannot wrap back into range.
    assign w_x_end = {1'b0, w_eff_x} + {1'b0, w_eff_w};
    assign w_y_end = {1'b0, w_eff_y} + {1'b0, w_eff_h};

    assign w_reject = (r_op == OP_RSVD) || (w_eff_w == '0) || (w_eff_h == '0) ||
                      (w_x_end > X_LIMIT) || (w_y_end > Y_LIMIT);

    assign w_start_addr    = ADDRW'(w_eff_y) * A_STRIDE + ADDRW'(w_eff_x);
    assign w_next_row_base = r_row_base + A_STRIDE;

    assign w_col_last = (r_col == r_w - X_ONE);
    assign w_row_last = (r_row == r_h - Y_ONE);

    // Nothing is consumed outside the blanking window, so position simply holds.
    assign w_consume = (r_state == S_WRITE) && bus.blank &&
                       ((r_op != OP_STREAM) || bus.pix_valid);

    always_comb begin
        w_elem_data = r_colr;
        if (r_op == OP_STREAM) begin
            w_elem_data = bus.pix_data;
        end else if (r_op == OP_CLEAR) begin
            w_elem_data = TRANSPARENT_VAL;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next_state = S_CHECK;
            S_CHECK: w_next_state = w_reject ? S_ERR : S_WRITE;
            S_WRITE: if (w_consume && w_col_last && w_row_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_colr     <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_consume;

            if ((r_state == S_IDLE) && bus.cmd_valid) begin
                r_op   <= bus.cmd_op;
                r_x    <= bus.cmd_x;
                r_y    <= bus.cmd_y;
                r_w    <= bus.cmd_w;
                r_h    <= bus.cmd_h;
                r_colr <= bus.cmd_colr;
            end

            if (r_state == S_CHECK) begin
                r_x        <= w_eff_x;
                r_y        <= w_eff_y;
                r_w        <= w_eff_w;
                r_h        <= w_eff_h;
                r_addr     <= w_start_addr;
                r_row_base <= w_start_addr;
                r_col      <= '0;
                r_row      <= '0;
            end

            if (w_consume) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_elem_data;
                if (!w_col_last) begin
                    r_addr <= r_addr + ADDRW'(1);
                    r_col  <= r_col + X_ONE;
                end else begin
                    r_row_base <= w_next_row_base;
                    r_addr     <= w_next_row_base;
                    r_col      <= '0;
                    r_row      <= r_row + Y_ONE;
                end
            end
        end
    end

    // rst_n gates cmd_ready so it stays low for the whole reset, not just after the first edge.
    assign bus.cmd_ready = rst_n && (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_ERR);
    assign bus.pix_ready = (r_state == S_WRITE) && (r_op == OP_STREAM) && bus.blank;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
endmodule

// File: tb/tb_sprite_mem_writer.sv
// tb/tb_sprite_mem_writer.sv - directed self-checking bench for sprite_mem_writer
module tb_sprite_mem_writer;
    localparam int WIDTH     = 10;
    localparam int HEIGHT    = 10;
    localparam int COLR_BITS = 12;
    localparam int ADDRW     = 7;
    localparam int XW        = 4;
    localparam int YW        = 4;

    logic clk_pix = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_pix = ~clk_pix;

    sprite_mem_writer_if #(.COLR_BITS(COLR_BITS), .ADDRW(ADDRW), .XW(XW), .YW(YW)) bus ();

    sprite_mem_writer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLR_BITS(COLR_BITS),
        .TRANSPARENT_VAL(12'h888), .ADDRW(ADDRW), .XW(XW), .YW(YW)
    ) dut (
        .clk_pix(clk_pix),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write/status log captured on the falling edge.
    int   cyc = 0;
    int   wr_addr_q[$];
    int   wr_data_q[$];
    int   wr_cyc_q[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic done_wr  = 1'b0;
    logic err_wr   = 1'b0;
    int   done_addr = 0;

    always @(negedge clk_pix) begin
        cyc++;
        if (rst_n) begin
            if (bus.wr_en === 1'b1) begin
                wr_addr_q.push_back(int'(bus.wr_addr));
                wr_data_q.push_back(int'(bus.wr_data));
                wr_cyc_q.push_back(cyc);
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_wr   = bus.wr_en;
                done_addr = int'(bus.wr_addr);
            end
            if (bus.err === 1'b1) begin
                err_cnt++;
                if (bus.wr_en === 1'b1) err_wr = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk_pix);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        done_wr   = 1'b0;
        err_wr    = 1'b0;
        done_addr = 0;
    endtask

    task automatic issue(input logic [1:0] op, input int x, input int y, input int w, input int h,
                         input int colr);
        int n;
        bus.cmd_op    = op;
        bus.cmd_x     = x[XW-1:0];
        bus.cmd_y     = y[YW-1:0];
        bus.cmd_w     = w[XW-1:0];
        bus.cmd_h     = h[YW-1:0];
        bus.cmd_colr  = colr[COLR_BITS-1:0];
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("issue_timeout", 32'd1, 32'd0);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic send_pix(input int d);
        int n;
        bus.pix_data  = d[COLR_BITS-1:0];
        bus.pix_valid = 1'b1;
        n = 0;
        while (bus.pix_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("pix_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic check_writes(input string tag, input int ea[$], input int ed[$]);
        check({tag, "_count"}, wr_addr_q.size(), ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wr_addr_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], ea[i]);
                check($sformatf("%s_data%0d", tag, i), wr_data_q[i], ed[i]);
            end
        end
    endtask

    initial begin
        int ea[$];
        int ed[$];
        int n;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_colr  = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.blank     = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_done_err", {bus.done, bus.err, bus.pix_ready}, 0);
        rst_n = 1'b1;
        step();
        check("rel_cmd_ready", bus.cmd_ready, 1);

        // 1: FILL 3x2 at (2,3)
        clear_log();
        issue(2'd1, 2, 3, 3, 2, 12'hF00);
        wait_idle("t1");
        ea = '{32, 33, 34, 42, 43, 44};
        ed = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00};
        check_writes("t1", ea, ed);
        if (wr_cyc_q.size() == 6) check("t1_consecutive", wr_cyc_q[5] - wr_cyc_q[0], 5);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_with_wr", done_wr, 1);
        check("t1_done_addr", done_addr, 44);
        check("t1_cmd_ready", bus.cmd_ready, 1);

        // 2: STREAM 2x2 with a two-cycle pix_valid gap after B
        clear_log();
        issue(2'd0, 0, 0, 2, 2, 0);
        send_pix(12'h00A);
        send_pix(12'h00B);
        bus.pix_valid = 1'b0;
        repeat (2) step();
        send_pix(12'h00C);
        send_pix(12'h00D);
        bus.pix_valid = 1'b0;
        wait_idle("t2");
        ea = '{0, 1, 10, 11};
        ed = '{12'h00A, 12'h00B, 12'h00C, 12'h00D};
        check_writes("t2", ea, ed);
        if (wr_cyc_q.size() == 4) check("t2_gap", wr_cyc_q[2] - wr_cyc_q[1], 3);
        check("t2_done_addr", done_addr, 11);

        // 3: FILL 4x1, blank low for 3 cycles after the 2nd element
        clear_log();
        issue(2'd1, 0, 0, 4, 1, 12'h0F0);
        step();
        step();
        step();
        bus.blank = 1'b0;
        repeat (3) step();
        bus.blank = 1'b1;
        wait_idle("t3");
        ea = '{0, 1, 2, 3};
        ed = '{12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
        check_writes("t3", ea, ed);
        if (wr_cyc_q.size() == 4) check("t3_blank_gap", wr_cyc_q[2] - wr_cyc_q[1], 4);

        // 4: rejected commands (x overflow, reserved op, zero width)
        for (int k = 0; k < 3; k++) begin
            clear_log();
            case (k)
                0:       issue(2'd1, 8, 0, 3, 1, 12'h123);
                1:       issue(2'd3, 0, 0, 1, 1, 12'h123);
                default: issue(2'd1, 0, 0, 0, 1, 12'h123);
            endcase
            wait_idle("t4");
            check($sformatf("t4_%0d_err_cnt", k), err_cnt, 1);
            check($sformatf("t4_%0d_writes", k), wr_addr_q.size(), 0);
            check($sformatf("t4_%0d_done_cnt", k), done_cnt, 0);
            check($sformatf("t4_%0d_err_wr", k), err_wr, 0);
            check($sformatf("t4_%0d_cmd_ready", k), bus.cmd_ready, 1);
        end

        // 4b: rectangle touching the bottom-right corner is accepted
        clear_log();
        issue(2'd1, 7, 9, 3, 1, 12'h0AB);
        wait_idle("t4b");
        ea = '{97, 98, 99};
        ed = '{12'h0AB, 12'h0AB, 12'h0AB};
        check_writes("t4b", ea, ed);
        check("t4b_err_cnt", err_cnt, 0);

        // 5: CLEAR whole sprite
        clear_log();
        issue(2'd2, 3, 3, 1, 1, 12'h555);
        wait_idle("t5");
        ea.delete();
        ed.delete();
        for (int i = 0; i < WIDTH*HEIGHT; i++) begin
            ea.push_back(i);
            ed.push_back(12'h888);
        end
        check_writes("t5", ea, ed);
        check("t5_done_with_wr", done_wr, 1);
        check("t5_done_addr", done_addr, 99);

        // 6: reset in the middle of a STREAM
        clear_log();
        issue(2'd0, 0, 0, 4, 4, 0);
        bus.pix_data  = 12'h123;
        bus.pix_valid = 1'b1;
        n = 0;
        while (wr_addr_q.size() < 3 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("t6_timeout", 32'd1, 32'd0);
        rst_n = 1'b0;
        step();
        check("t6_rst_wr_en", bus.wr_en, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_cmd_ready", bus.cmd_ready, 0);
        check("t6_rst_pix_ready", bus.pix_ready, 0);
        check("t6_writes_before", wr_addr_q.size(), 3);
        bus.pix_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("t6_rel_cmd_ready", bus.cmd_ready, 1);
        check("t6_rel_busy", bus.busy, 0);
        check("t6_no_more_writes", wr_addr_q.size(), 3);
        clear_log();
        issue(2'd1, 1, 1, 2, 1, 12'h0F0);
        wait_idle("t6b");
        ea = '{11, 12};
        ed = '{12'h0F0, 12'h0F0};
        check_writes("t6b", ea, ed);
        check("t6b_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sprite_mem_writer.md
Name: sprite_mem_writer

Overview:
- Write-side counterpart of the sprite renderer. The renderer only reads sprite pixel memory; this block writes it.
- Accepts rectangle write commands and updates a dual-port sprite RAM: STREAM writes supplied pixels, FILL writes a constant colour, CLEAR writes the transparent value to the whole sprite.
- Writes are issued only while the external `blank` window is high, so the renderer never reads a half-updated sprite mid-frame.
- Used for explosion animation and damage effects on bunkers and ships.

Parameters:
- WIDTH, 10, sprite width in pixels (row stride of RAM).
- HEIGHT, 10, sprite height in pixels.
- COLR_BITS, 12, bits per pixel colour.
- TRANSPARENT_VAL, 12'h888, colour written by CLEAR.
- ADDRW, $clog2(WIDTH*HEIGHT), RAM address width.
- XW, $clog2(WIDTH+1), width of x/w command fields.
- YW, $clog2(HEIGHT+1), width of y/h command fields.

Ports:
- clk_pix  in  1  pixel clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle, can accept a command.
- cmd_op  in  2  0=STREAM, 1=FILL, 2=CLEAR, 3=reserved (illegal).
- cmd_x  in  XW  rectangle left column.
- cmd_y  in  YW  rectangle top row.
- cmd_w  in  XW  rectangle width.
- cmd_h  in  YW  rectangle height.
- cmd_colr  in  COLR_BITS  FILL colour.
- pix_valid  in  1  STREAM pixel offered.
- pix_ready  out  1  STREAM pixel accepted this cycle when pix_valid is also high.
- pix_data  in  COLR_BITS  STREAM pixel colour.
- blank  in  1  safe-write window (vertical blanking).
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDRW  RAM address = y*WIDTH + x.
- wr_data  out  COLR_BITS  RAM write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
Reset:
- Applies on the clk_pix edge with rst_n=0.
- State=IDLE. wr_en=0, wr_addr=0, wr_data=0, pix_ready=0, busy=0, done=0, err=0, cmd_ready=0 while rst_n=0.
- Reset mid-command discards the command; no further writes. The first cycle after release has cmd_ready=1.

States:
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd fields and go to CHECK.
- CHECK (1 cycle):
  - CLEAR overrides to x=0, y=0, w=WIDTH, h=HEIGHT.
  - Reject if op==3, w==0, h==0, x+w>WIDTH or y+h>HEIGHT; sums are computed one bit wider, with no wrap.
  - Reject -> ERR. Otherwise load addr=y*WIDTH+x, row_base=addr, col=0, row=0, go to WRITE.
- WRITE:
  - FILL/CLEAR: one element per cycle while blank=1.
  - STREAM: pix_ready = blank; one element per cycle on pix_valid&&pix_ready.
  - No element is consumed while blank=0; position is held and resumes when blank returns.
  - Last element (col==w-1 && row==h-1) consumed -> DONE.
- DONE (1 cycle): done=1, then IDLE.
- ERR (1 cycle): err=1, no writes, then IDLE.

Write timing:
- wr_en, wr_addr and wr_data are registered.
- An element consumed in cycle N produces wr_en=1 in cycle N+1 with that element's address and data.
- The final write therefore coincides with the done pulse.
- wr_addr and wr_data hold their last values when wr_en=0.

Address stepping:
- col<w-1: addr+1.
- End of row: row_base += WIDTH, addr = new row_base, col=0, row+1.
- Addresses never exceed WIDTH*HEIGHT-1 for accepted commands.

Handshake and status:
- busy=1 in CHECK, WRITE, DONE and ERR.
- cmd_ready=0 whenever busy=1.
- pix_ready=0 outside WRITE and outside STREAM.
- Input pixels offered outside STREAM/WRITE are ignored, not consumed.

Simultaneous events:
- blank falling in the same cycle as a pixel handshake: the value sampled that cycle governs; an element is consumed only if blank=1 that cycle.
- cmd_valid while busy: not accepted, stays pending.

Test Plan:
1. WIDTH=HEIGHT=10, blank=1, FILL x=2 y=3 w=3 h=2 colr=12'hF00 -> 6 consecutive wr_en cycles, addr 32,33,34,42,43,44, data F00; done pulses with the addr-44 write; cmd_ready=1 next cycle.
2. STREAM x=0 y=0 w=2 h=2, pixels 0xA,0xB,0xC,0xD with pix_valid low for 2 cycles after B -> writes addr 0,1,10,11 with A,B,C,D in order; no wr_en during the gap.
3. FILL x=0 y=0 w=4 h=1, blank low for 3 cycles after 2nd element -> wr_en low 3 cycles; total 4 writes, addr 0..3; no duplicates or skips.
4. FILL x=8 w=3 h=1, also op=3 -> err one-cycle pulse, zero wr_en, busy low afterwards, cmd_ready=1.
5. CLEAR -> 100 writes, addr 0..99 ascending, data 12'h888; done with the final write.
6. STREAM w=4 h=4, assert rst_n=0 after the 3rd write -> wr_en=0 the next cycle; after release cmd_ready=1, busy=0; a new FILL then executes correctly.
